// File: rtl/decode_sequencer.sv
// Buffered instruction decoder: a small FIFO feeds a head decoder and a step
// sequencer that walks the register-file operand accesses of each instruction.
module decode_sequencer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       in_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [1:0]        ALUop,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic [2:0]        nsel,
    output logic [2:0]        regnum,
    output logic              rd_en,
    output logic              wr_en,
    output logic              last,
    output logic              illegal,
    output logic              halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;
    // step flag triplets {rd, wr, last}
    localparam logic [2:0] F_R  = 3'b100;
    localparam logic [2:0] F_RL = 3'b101;
    localparam logic [2:0] F_WL = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP1 = 3'd1,
        S_STEP2 = 3'd2,
        S_STEP3 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Step descriptor {nsel, rd, wr, last} for step idx (1..3) of an instruction; 0 = no such step.
    function automatic logic [5:0] step_info(input logic [2:0] opc, input logic [1:0] opx,
                                             input logic [1:0] idx);
        logic [5:0] s1;
        logic [5:0] s2;
        logic [5:0] s3;
        logic [5:0] r;
        s1 = 6'd0;
        s2 = 6'd0;
        s3 = 6'd0;
        case ({opc, opx})
            5'b110_10: s1 = {NSEL_RN, F_WL};
            5'b110_00: begin s1 = {NSEL_RM, F_R}; s2 = {NSEL_RD, F_WL}; end
            5'b101_00,
            5'b101_10: begin s1 = {NSEL_RN, F_R}; s2 = {NSEL_RM, F_R}; s3 = {NSEL_RD, F_WL}; end
            5'b101_01: begin s1 = {NSEL_RN, F_R}; s2 = {NSEL_RM, F_RL}; end
            5'b101_11: begin s1 = {NSEL_RM, F_R}; s2 = {NSEL_RD, F_WL}; end
            5'b011_00: begin s1 = {NSEL_RN, F_R}; s2 = {NSEL_RD, F_WL}; end
            5'b100_00: begin s1 = {NSEL_RN, F_R}; s2 = {NSEL_RD, F_RL}; end
            default:   s1 = 6'd0;
        endcase
        case (idx)
            2'd1:    r = s1;
            2'd2:    r = s2;
            2'd3:    r = s3;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] state_idx(input state_t st);
        logic [1:0] r;
        case (st)
            S_STEP1: r = 2'd1;
            S_STEP2: r = 2'd2;
            S_STEP3: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [15:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [15:0]   head_s;
    logic          head_halt_s;
    logic          head_legal_s;
    logic [5:0]    cur_info_s;
    logic [5:0]    nxt_info_s;

    state_t     state_r;
    state_t     state_nxt;
    logic [2:0] nsel_r;
    logic [2:0] nsel_nxt;
    logic [2:0] regnum_r;
    logic [2:0] regnum_nxt;
    logic       rd_en_r;
    logic       rd_en_nxt;
    logic       wr_en_r;
    logic       wr_en_nxt;
    logic       last_r;
    logic       last_nxt;
    logic       illegal_r;
    logic       illegal_nxt;
    logic       halted_r;

    assign empty_s  = (count_r == {CW{1'b0}});
    assign in_ready = (count_r != DEPTH_C);
    assign push_s   = in_valid && in_ready;

    // Decoded fields read straight from the head entry; all zero when the FIFO is empty.
    assign head_s       = empty_s ? 16'd0 : mem_r[rd_ptr_r];
    assign opcode       = head_s[15:13];
    assign op           = head_s[12:11];
    assign ALUop        = head_s[12:11];
    assign shift        = head_s[4:3];
    assign sximm5       = {{(DATA_W-5){head_s[4]}}, head_s[4:0]};
    assign sximm8       = {{(DATA_W-8){head_s[7]}}, head_s[7:0]};
    assign head_halt_s  = (head_s[15:13] == 3'b111);
    assign head_legal_s = (step_info(head_s[15:13], head_s[12:11], 2'd1) != 6'd0);
    assign cur_info_s   = step_info(head_s[15:13], head_s[12:11], state_idx(state_r));

    // Instruction FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'd0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_instr;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Next state, pop decision and next registered step outputs.
    always_comb begin
        state_nxt   = state_r;
        pop_s       = 1'b0;
        illegal_nxt = 1'b0;
        if (!stall) begin
            case (state_r)
                S_IDLE: begin
                    if (!empty_s) begin
                        if (head_halt_s) begin
                            pop_s     = 1'b1;
                            state_nxt = S_HALT;
                        end else if (!head_legal_s) begin
                            pop_s       = 1'b1;
                            illegal_nxt = 1'b1;
                        end else begin
                            state_nxt = S_STEP1;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_STEP1, S_STEP2, S_STEP3: begin
                    if (cur_info_s[0] || (state_r == S_STEP3)) begin
                        pop_s     = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (state_r == S_STEP1) begin
                        state_nxt = S_STEP2;
                    end else begin
                        state_nxt = S_STEP3;
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_IDLE;
            endcase
        end else begin
            state_nxt = state_r;
        end

        nxt_info_s = step_info(head_s[15:13], head_s[12:11], state_idx(state_nxt));
        if (stall) begin
            nsel_nxt   = nsel_r;
            regnum_nxt = regnum_r;
            rd_en_nxt  = rd_en_r;
            wr_en_nxt  = wr_en_r;
            last_nxt   = last_r;
        end else begin
            nsel_nxt  = nxt_info_s[5:3];
            rd_en_nxt = nxt_info_s[2];
            wr_en_nxt = nxt_info_s[1];
            last_nxt  = nxt_info_s[0];
            case (nxt_info_s[5:3])
                NSEL_RN: regnum_nxt = head_s[10:8];
                NSEL_RD: regnum_nxt = head_s[7:5];
                NSEL_RM: regnum_nxt = head_s[2:0];
                default: regnum_nxt = 3'd0;
            endcase
        end
    end

    // State and registered step outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            nsel_r    <= 3'd0;
            regnum_r  <= 3'd0;
            rd_en_r   <= 1'b0;
            wr_en_r   <= 1'b0;
            last_r    <= 1'b0;
            illegal_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            nsel_r    <= nsel_nxt;
            regnum_r  <= regnum_nxt;
            rd_en_r   <= rd_en_nxt;
            wr_en_r   <= wr_en_nxt;
            last_r    <= last_nxt;
            illegal_r <= illegal_nxt;
            halted_r  <= (state_nxt == S_HALT);
        end
    end

    assign nsel    = nsel_r;
    assign regnum  = regnum_r;
    assign rd_en   = rd_en_r;
    assign wr_en   = wr_en_r;
    assign last    = last_r;
    assign illegal = illegal_r;
    assign halted  = halted_r;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: a vector table of single instructions
// plus hand-written stall, full-FIFO, halt and reset sequences.
module tb_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        stall;

    logic        in_ready, rd_en, wr_en, last, illegal, halted;
    logic [2:0]  opcode, nsel, regnum;
    logic [1:0]  op, ALUop, shift;
    logic [15:0] sximm5, sximm8;

    logic        in_ready_w, rd_en_w, wr_en_w, last_w, illegal_w, halted_w;
    logic [2:0]  opcode_w, nsel_w, regnum_w;
    logic [1:0]  op_w, ALUop_w, shift_w;
    logic [31:0] sximm5_w, sximm8_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_sequencer #(.DATA_W(16), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .stall(stall), .opcode(opcode), .op(op), .ALUop(ALUop),
        .shift(shift), .sximm5(sximm5), .sximm8(sximm8), .nsel(nsel), .regnum(regnum),
        .rd_en(rd_en), .wr_en(wr_en), .last(last), .illegal(illegal), .halted(halted)
    );

    decode_sequencer #(.DATA_W(32), .DEPTH(2)) dut_w (
        .clk(clk), .reset_n(reset_n), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready_w), .stall(stall), .opcode(opcode_w), .op(op_w), .ALUop(ALUop_w),
        .shift(shift_w), .sximm5(sximm5_w), .sximm8(sximm8_w), .nsel(nsel_w), .regnum(regnum_w),
        .rd_en(rd_en_w), .wr_en(wr_en_w), .last(last_w), .illegal(illegal_w), .halted(halted_w)
    );

    typedef struct {
        logic [15:0]      instr;
        int               nsteps;
        logic             bad;
        logic [2:0]       opc;
        logic [1:0]       opx;
        logic [1:0]       sh;
        logic [15:0]      imm5;
        logic [15:0]      imm8;
        logic [2:0][7:0]  st;   // per step {nsel, regnum, rd_en, wr_en}
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] stp(input logic [2:0] n, input logic [2:0] r,
                                       input logic rd, input logic wr);
        return {n, r, rd, wr};
    endfunction

    task automatic set_vec(input int i, input logic [15:0] instr, input int n, input logic bad,
                           input logic [2:0] opc, input logic [1:0] opx, input logic [1:0] sh,
                           input logic [15:0] i5, input logic [15:0] i8,
                           input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
        vecs[i].instr = instr; vecs[i].nsteps = n; vecs[i].bad = bad;
        vecs[i].opc = opc; vecs[i].opx = opx; vecs[i].sh = sh;
        vecs[i].imm5 = i5; vecs[i].imm8 = i8;
        vecs[i].st[0] = s1; vecs[i].st[1] = s2; vecs[i].st[2] = s3;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        in_instr = 16'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [15:0] w);
        in_instr = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_nsel(input logic [2:0] target, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (nsel == target) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [5:0] seq[$];
        logic [5:0] exp_seq[6];
        bit         hs;
        bit         any_step;

        set_vec(0,  16'hA143, 3, 1'b0, 3'd5, 2'd0, 2'd0, 16'h0003, 16'h0043,
                stp(3'b001,3'd1,1,0), stp(3'b100,3'd3,1,0), stp(3'b010,3'd2,0,1));
        set_vec(1,  16'hD5FD, 1, 1'b0, 3'd6, 2'd2, 2'd3, 16'hFFFD, 16'hFFFD,
                stp(3'b001,3'd5,0,1), 8'd0, 8'd0);
        set_vec(2,  16'hC086, 2, 1'b0, 3'd6, 2'd0, 2'd0, 16'h0006, 16'hFF86,
                stp(3'b100,3'd6,1,0), stp(3'b010,3'd4,0,1), 8'd0);
        set_vec(3,  16'hAB17, 2, 1'b0, 3'd5, 2'd1, 2'd2, 16'hFFF7, 16'h0017,
                stp(3'b001,3'd3,1,0), stp(3'b100,3'd7,1,0), 8'd0);
        set_vec(4,  16'hB82A, 2, 1'b0, 3'd5, 2'd3, 2'd1, 16'h000A, 16'h002A,
                stp(3'b100,3'd2,1,0), stp(3'b010,3'd1,0,1), 8'd0);
        set_vec(5,  16'h627F, 2, 1'b0, 3'd3, 2'd0, 2'd3, 16'hFFFF, 16'h007F,
                stp(3'b001,3'd2,1,0), stp(3'b010,3'd3,0,1), 8'd0);
        set_vec(6,  16'h87B0, 2, 1'b0, 3'd4, 2'd0, 2'd2, 16'hFFF0, 16'hFFB0,
                stp(3'b001,3'd7,1,0), stp(3'b010,3'd5,1,0), 8'd0);
        set_vec(7,  16'hB4E5, 3, 1'b0, 3'd5, 2'd2, 2'd0, 16'h0005, 16'hFFE5,
                stp(3'b001,3'd4,1,0), stp(3'b100,3'd5,1,0), stp(3'b010,3'd7,0,1));
        set_vec(8,  16'h0000, 0, 1'b1, 3'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 8'd0, 8'd0, 8'd0);
        set_vec(9,  16'hD5FD, 1, 1'b0, 3'd6, 2'd2, 2'd3, 16'hFFFD, 16'hFFFD,
                stp(3'b001,3'd5,0,1), 8'd0, 8'd0);
        set_vec(10, 16'h3FFF, 0, 1'b1, 3'd1, 2'd3, 2'd3, 16'hFFFF, 16'hFFFF, 8'd0, 8'd0, 8'd0);

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_steps", {nsel, regnum, rd_en, wr_en, last, illegal, halted}, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);

        // single-instruction vectors
        foreach (vecs[i]) begin
            push_one(vecs[i].instr);
            chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].opc));
            chk($sformatf("v%0d_op", i), {op, ALUop}, 32'({vecs[i].opx, vecs[i].opx}));
            chk($sformatf("v%0d_shift", i), 32'(shift), 32'(vecs[i].sh));
            chk($sformatf("v%0d_sximm5", i), 32'(sximm5), 32'(vecs[i].imm5));
            chk($sformatf("v%0d_sximm8", i), 32'(sximm8), 32'(vecs[i].imm8));
            chk($sformatf("v%0d_sximm8_w", i), sximm8_w, {{16{vecs[i].imm8[15]}}, vecs[i].imm8});
            chk($sformatf("v%0d_sximm5_w", i), sximm5_w, {{16{vecs[i].imm5[15]}}, vecs[i].imm5});
            chk($sformatf("v%0d_idle", i), 32'(nsel), 32'd0);
            if (vecs[i].bad) begin
                tick();
                chk($sformatf("v%0d_illegal", i), {illegal, rd_en, wr_en, nsel}, 32'h20);
                tick();
                chk($sformatf("v%0d_illegal_end", i), 32'(illegal), 32'd0);
            end else begin
                for (int k = 0; k < vecs[i].nsteps; k++) begin
                    tick();
                    chk($sformatf("v%0d_step%0d", i, k + 1), {nsel, regnum, rd_en, wr_en},
                        32'(vecs[i].st[k]));
                    chk($sformatf("v%0d_last%0d", i, k + 1), 32'(last),
                        32'(k == vecs[i].nsteps - 1));
                end
                tick();
                chk($sformatf("v%0d_bubble", i), 32'(nsel), 32'd0);
            end
            chk($sformatf("v%0d_empty", i), {opcode, 13'd0, in_ready}, 32'd1);
        end

        // stall with a full FIFO, third word held until space frees up
        stall = 1'b1;
        push_one(16'hA143);
        chk("full_rdy1", 32'(in_ready), 32'd1);
        in_instr = 16'hD5FD;
        in_valid = 1'b1;
        tick();
        chk("full_rdy0", 32'(in_ready), 32'd0);
        in_instr = 16'hC086;
        tick();
        tick();
        chk("full_hold", {in_ready, nsel, opcode}, 32'h05);
        stall = 1'b0;
        hs = 1'b0;
        for (int c = 0; c < 20; c++) begin
            hs = in_valid && in_ready;
            tick();
            if (hs) in_valid = 1'b0;
            if (nsel != 3'd0) seq.push_back({nsel, regnum});
        end
        chk("full_third_taken", 32'(in_valid), 32'd0);
        exp_seq = '{{3'b001,3'd1}, {3'b100,3'd3}, {3'b010,3'd2},
                    {3'b001,3'd5}, {3'b100,3'd6}, {3'b010,3'd4}};
        chk("full_seq_len", 32'(seq.size()), 32'd6);
        for (int k = 0; k < 6 && k < seq.size(); k++) begin
            chk($sformatf("full_seq%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
        end
        chk("full_drained", 32'(opcode), 32'd0);

        // stall held through ADD step 2
        push_one(16'hA143);
        wait_nsel(3'b100, "stall_reach_s2");
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_hold%0d", c), {nsel, regnum, rd_en, wr_en, last}, {27'd0, 3'b100, 3'd3, 3'b100});
        end
        stall = 1'b0;
        tick();
        chk("stall_resume", {nsel, regnum, rd_en, wr_en, last}, {27'd0, 3'b010, 3'd2, 3'b011});
        tick();
        chk("stall_done", 32'(nsel), 32'd0);

        // HALT is sticky and stops all pops
        push_one(16'hE000);
        tick();
        chk("halt_set", {halted, nsel, opcode}, 32'h40);
        push_one(16'hA143);
        push_one(16'hD5FD);
        chk("halt_full", 32'(in_ready), 32'd0);
        for (int c = 0; c < 5; c++) tick();
        chk("halt_stuck", {halted, nsel, rd_en, wr_en, opcode}, 32'h105);

        // reset in the middle of an ADD aborts it
        do_reset();
        chk("rst2_halt_clear", 32'(halted), 32'd0);
        push_one(16'hA143);
        wait_nsel(3'b100, "rst_reach_s2");
        reset_n = 1'b0;
        #1;
        chk("rst_async", {nsel, regnum, rd_en, wr_en, last, in_ready, opcode}, 32'h8);
        tick();
        reset_n = 1'b1;
        any_step = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (nsel != 3'd0) any_step = 1'b1;
        end
        chk("rst_no_resume", 32'(any_step), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
